// File: rtl/mem_responder.sv
// Memory-side responder: wait states, RAM, LED and switch I/O.
// Define MEM_RESP_IO_EN to decode the LED register and switch port.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 16,
  parameter int RAM_AW      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [9:0]        sw,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              mem_err,
  output logic [7:0]        leds,
  output logic              busy
);

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam logic [1:0] MILL   = 2'b11;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [1:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;
  logic              err_q;

  logic [DATA_W-1:0] ram_q [2**RAM_AW];

  logic              accept;
  logic              go_resp;
  logic [1:0]        cmd_e;
  logic [ADDR_W-1:0] addr_e;
  logic [DATA_W-1:0] data_e;
  logic [RAM_AW-1:0] ram_idx;
  logic              is_rd;
  logic              is_wr;
  logic              is_ram;
  logic              ram_we;
  logic              led_we;
  logic [DATA_W-1:0] rdata_d;
  logic              err_d;

`ifdef MEM_RESP_IO_EN
  localparam logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(9'h100);
  localparam logic [ADDR_W-1:0] SW_ADDR  = ADDR_W'(9'h140);

  logic [7:0] leds_q;
  logic       is_led;
  logic       is_sw;

  assign is_led = (addr_e == LED_ADDR);
  assign is_sw  = (addr_e == SW_ADDR);
  assign leds   = leds_q;
`else
  logic unused_sw;

  assign unused_sw = ^sw;
  assign leds      = 8'h00;
`endif

  // Direct IDLE->RESP (no wait states) must use the live bus.
  assign accept  = (state_q == S_IDLE) && (mem_cmd != MNONE);
  assign go_resp = (accept && NO_WAIT) ||
                   ((state_q == S_WAIT) && (cnt_q == 4'd0));
  assign cmd_e   = (state_q == S_IDLE) ? mem_cmd : cmd_q;
  assign addr_e  = (state_q == S_IDLE) ? mem_addr : addr_q;
  assign data_e  = (state_q == S_IDLE) ? write_data : data_q;
  assign ram_idx = addr_e[RAM_AW-1:0];
  assign is_rd   = (cmd_e == MREAD);
  assign is_wr   = (cmd_e == MWRITE);
  assign is_ram  = ~addr_e[ADDR_W-1];
  assign ram_we  = go_resp && is_wr && is_ram && !rst;

  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    led_we  = 1'b0;
    unique case (1'b1)
      is_ram: begin
        if (is_rd) rdata_d = ram_q[ram_idx];
      end
`ifdef MEM_RESP_IO_EN
      is_led: begin
        if (is_wr) led_we = 1'b1;
        if (is_rd) rdata_d = DATA_W'(leds_q);
      end
      is_sw: begin
        if (is_wr) err_d = 1'b1;
        if (is_rd) rdata_d = DATA_W'(sw);
      end
`endif
      default: err_d = 1'b1;
    endcase
    if (cmd_e == MILL) begin
      rdata_d = '0;
      err_d   = 1'b1;
      led_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= data_e;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      cmd_q   <= MNONE;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef MEM_RESP_IO_EN
      leds_q  <= 8'h00;
`endif
    end else begin
      ready_q <= go_resp;
      err_q   <= go_resp && err_d;
      rdata_q <= go_resp ? rdata_d : '0;
`ifdef MEM_RESP_IO_EN
      if (go_resp && led_we) leds_q <= data_e[7:0];
`endif
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            cmd_q   <= mem_cmd;
            addr_q  <= mem_addr;
            data_q  <= write_data;
            cnt_q   <= CNT_LOAD;
            state_q <= NO_WAIT ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_q <= S_RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign read_data = rdata_q;
  assign mem_ready = ready_q;
  assign mem_err   = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with 0, 1 and 3 wait states.
// I/O checks follow MEM_RESP_IO_EN.
module tb_mem_responder;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam logic [1:0] MILL   = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  sw;
  logic [1:0]  cmd  [3];
  logic [8:0]  addr [3];
  logic [15:0] wd   [3];
  logic [15:0] rd   [3];
  logic        rdy  [3];
  logic        er   [3];
  logic        bsy  [3];
  logic [7:0]  led  [3];

  int checks = 0;
  int errors = 0;
  int pulses2 = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (rdy[2] === 1'b1) pulses2 <= pulses2 + 1;

  mem_responder #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .mem_cmd(cmd[0]), .mem_addr(addr[0]),
    .write_data(wd[0]), .sw(sw), .read_data(rd[0]), .mem_ready(rdy[0]),
    .mem_err(er[0]), .leds(led[0]), .busy(bsy[0])
  );

  mem_responder #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .mem_cmd(cmd[1]), .mem_addr(addr[1]),
    .write_data(wd[1]), .sw(sw), .read_data(rd[1]), .mem_ready(rdy[1]),
    .mem_err(er[1]), .leds(led[1]), .busy(bsy[1])
  );

  mem_responder #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .mem_cmd(cmd[2]), .mem_addr(addr[2]),
    .write_data(wd[2]), .sw(sw), .read_data(rd[2]), .mem_ready(rdy[2]),
    .mem_err(er[2]), .leds(led[2]), .busy(bsy[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command; lat = edges from the sampling edge (1) to the
  // edge after which mem_ready is seen; 0 means it never came.
  task automatic txn(input int u, input logic [1:0] c,
                     input logic [8:0] a, input logic [15:0] d,
                     output logic [15:0] rdv, output logic erv,
                     output int lat);
    cmd[u]  = c;
    addr[u] = a;
    wd[u]   = d;
    lat = 0;
    rdv = 'x;
    erv = 'x;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) cmd[u] = MNONE;
      if (rdy[u] === 1'b1) begin
        lat = k;
        rdv = rd[u];
        erv = er[u];
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      cmd[u] = MREAD;
      addr[u] = 9'h005;
      wd[u] = 16'h0;
    end
    for (int n = 0; n < 2; n++) begin
      tick();
      for (int u = 0; u < 3; u++) begin
        checks++;
        if ({rdy[u], er[u], bsy[u], rd[u], led[u]} !== 27'h0) begin
          errors++;
          $display("FAIL reset_outs u%0d got %b/%b/%b/%h/%h exp 0",
                   u, rdy[u], er[u], bsy[u], rd[u], led[u]);
        end
      end
    end
    rst = 1'b0;
    for (int u = 0; u < 3; u++) cmd[u] = MNONE;
    tick();
    for (int u = 0; u < 3; u++) begin
      checks++;
      if ({rdy[u], bsy[u]} !== 2'b00) begin
        errors++;
        $display("FAIL reset_release u%0d got rdy=%b busy=%b exp 0 0",
                 u, rdy[u], bsy[u]);
      end
    end
  endtask

  task automatic test_ram_roundtrip();
    logic [15:0] r;
    logic e;
    int l;
    txn(1, MWRITE, 9'h005, 16'h1234, r, e, l);
    checks++;
    if ({l[7:0], e, r} !== {8'd2, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL ram_wr got lat=%0d err=%b rd=%h exp 2 0 0000", l, e, r);
    end
    txn(1, MREAD, 9'h005, 16'h0, r, e, l);
    checks++;
    if ({l[7:0], e, r} !== {8'd2, 1'b0, 16'h1234}) begin
      errors++;
      $display("FAIL ram_rd got lat=%0d err=%b rd=%h exp 2 0 1234", l, e, r);
    end
  endtask

  task automatic test_latency();
    logic [15:0] r;
    logic e;
    int l;
    txn(0, MWRITE, 9'h0AA, 16'hCAFE, r, e, l);
    checks++;
    if (l !== 1) begin
      errors++;
      $display("FAIL w0_wr_lat got %0d exp 1", l);
    end
    txn(0, MREAD, 9'h0AA, 16'h0, r, e, l);
    checks++;
    if ({l[7:0], e, r} !== {8'd1, 1'b0, 16'hCAFE}) begin
      errors++;
      $display("FAIL w0_rd got lat=%0d err=%b rd=%h exp 1 0 cafe", l, e, r);
    end
    txn(2, MWRITE, 9'h0FF, 16'h8001, r, e, l);
    txn(2, MREAD, 9'h0FF, 16'h0, r, e, l);
    checks++;
    if ({l[7:0], e, r} !== {8'd4, 1'b0, 16'h8001}) begin
      errors++;
      $display("FAIL w3_rd got lat=%0d err=%b rd=%h exp 4 0 8001", l, e, r);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] rdy_exp = 6'b010010;
    logic [5:0] bsy_exp = 6'b110110;
    logic [5:0] rdy_got;
    logic [5:0] bsy_got;
    cmd[1]  = MREAD;
    addr[1] = 9'h005;
    for (int k = 0; k < 6; k++) begin
      tick();
      rdy_got[5-k] = rdy[1];
      bsy_got[5-k] = bsy[1];
    end
    cmd[1] = MNONE;
    tick();
    checks++;
    if (rdy_got !== rdy_exp) begin
      errors++;
      $display("FAIL b2b_ready got %b exp %b", rdy_got, rdy_exp);
    end
    checks++;
    if (bsy_got !== bsy_exp) begin
      errors++;
      $display("FAIL b2b_busy got %b exp %b", bsy_got, bsy_exp);
    end
  endtask

`ifdef MEM_RESP_IO_EN
  task automatic test_io();
    logic [15:0] r;
    logic e;
    int l;
    txn(1, MWRITE, 9'h100, 16'hBEAB, r, e, l);
    checks++;
    if ({e, led[1]} !== {1'b0, 8'hAB}) begin
      errors++;
      $display("FAIL led_wr got err=%b leds=%h exp 0 ab", e, led[1]);
    end
    txn(1, MREAD, 9'h100, 16'h0, r, e, l);
    checks++;
    if ({e, r} !== {1'b0, 16'h00AB}) begin
      errors++;
      $display("FAIL led_rd got err=%b rd=%h exp 0 00ab", e, r);
    end
    sw = 10'h2A5;
    txn(1, MREAD, 9'h140, 16'h0, r, e, l);
    checks++;
    if ({e, r} !== {1'b0, 16'h02A5}) begin
      errors++;
      $display("FAIL sw_rd got err=%b rd=%h exp 0 02a5", e, r);
    end
    txn(1, MWRITE, 9'h140, 16'h0055, r, e, l);
    checks++;
    if ({l[7:0], e, led[1]} !== {8'd2, 1'b1, 8'hAB}) begin
      errors++;
      $display("FAIL sw_wr got lat=%0d err=%b leds=%h exp 2 1 ab",
               l, e, led[1]);
    end
  endtask
`else
  task automatic test_no_io();
    logic [15:0] r;
    logic e;
    int l;
    txn(1, MWRITE, 9'h100, 16'h00FF, r, e, l);
    checks++;
    if ({l[7:0], e, led[1]} !== {8'd2, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL noio_led_wr got lat=%0d err=%b leds=%h exp 2 1 00",
               l, e, led[1]);
    end
    sw = 10'h3FF;
    txn(1, MREAD, 9'h140, 16'h0, r, e, l);
    checks++;
    if ({e, r} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL noio_sw_rd got err=%b rd=%h exp 1 0000", e, r);
    end
  endtask
`endif

  task automatic test_unmapped_illegal();
    logic [15:0] r;
    logic e;
    int l;
    txn(1, MWRITE, 9'h010, 16'h5A5A, r, e, l);
    txn(1, MREAD, 9'h1FF, 16'h0, r, e, l);
    checks++;
    if ({l[7:0], e, r} !== {8'd2, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL unmapped_rd got lat=%0d err=%b rd=%h exp 2 1 0000",
               l, e, r);
    end
    txn(1, MILL, 9'h010, 16'h1111, r, e, l);
    checks++;
    if ({l[7:0], e, r} !== {8'd2, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL illegal got lat=%0d err=%b rd=%h exp 2 1 0000", l, e, r);
    end
    txn(1, MREAD, 9'h010, 16'h0, r, e, l);
    checks++;
    if ({e, r} !== {1'b0, 16'h5A5A}) begin
      errors++;
      $display("FAIL illegal_keep got err=%b rd=%h exp 0 5a5a", e, r);
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] r;
    logic e;
    int l;
    int base;
    txn(2, MWRITE, 9'h020, 16'h1357, r, e, l);
    base = pulses2;
    cmd[2]  = MWRITE;
    addr[2] = 9'h020;
    wd[2]   = 16'hFFFF;
    tick();
    cmd[2] = MNONE;
    tick();
    checks++;
    if ({bsy[2], rdy[2]} !== 2'b10) begin
      errors++;
      $display("FAIL abort_wait got busy=%b rdy=%b exp 1 0", bsy[2], rdy[2]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bsy[2], rdy[2]} !== 2'b00) begin
      errors++;
      $display("FAIL abort_rst got busy=%b rdy=%b exp 0 0", bsy[2], rdy[2]);
    end
    repeat (4) tick();
    txn(2, MREAD, 9'h020, 16'h0, r, e, l);
    checks++;
    if ({l[7:0], e, r} !== {8'd4, 1'b0, 16'h1357}) begin
      errors++;
      $display("FAIL abort_rd got lat=%0d err=%b rd=%h exp 4 0 1357", l, e, r);
    end
    checks++;
    if (pulses2 - base !== 1) begin
      errors++;
      $display("FAIL abort_pulses got %0d exp 1", pulses2 - base);
    end
  endtask

  initial begin
    sw = 10'h000;
    test_reset();
    test_ram_roundtrip();
    test_latency();
    test_back_to_back();
`ifdef MEM_RESP_IO_EN
    test_io();
`else
    test_no_io();
`endif
    test_unmapped_illegal();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
